// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Round-robin arbiter merging NREQ write ports onto a single
//            register-file write port, with a built-in register clear sequence.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_write_arbiter #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NREGS  = 8
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     stall,
  input  logic                     clear_start,
  output logic                     clear_busy,
  output logic [ADDR_W-1:0]        A3,
  output logic                     WE3,
  output logic [DATA_W-1:0]        WD3,
  output logic [1:0]               grant_id
);

  // One extra bit so the clear index can reach NREGS == 2**ADDR_W.
  localparam int                 c_CNT_W      = ADDR_W + 1;
  localparam logic [c_CNT_W-1:0] c_NREGS_CNT  = c_CNT_W'(NREGS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_last_grant;
  logic [c_CNT_W-1:0]   r_clr_idx;

  logic                 w_found;
  logic [1:0]           w_gnt;
  logic [1:0]           w_cand;
  logic                 w_hs;
  logic                 w_clr_go;
  logic [ADDR_W-1:0]    w_addr;
  logic [DATA_W-1:0]    w_data;

  // Rotating priority search starting just above the last granted requester.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = 2'((int'(r_last_grant) + k) % NREQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_gnt   = w_cand;
      end
    end
  end

  assign w_clr_go = !RESET && clear_start && (r_state != S_CLEAR);
  assign w_hs     = !RESET && (r_state == S_ARB) && !stall && !clear_start && w_found;

  always_comb begin
    req_ready = '0;
    w_addr    = '0;
    w_data    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_hs && (w_gnt == 2'(i))) begin
        req_ready[i] = 1'b1;
        w_addr       = req_addr[i*ADDR_W +: ADDR_W];
        w_data       = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = clear_start ? S_CLEAR : S_ARB;
      S_ARB:   if (clear_start) w_next = S_CLEAR;
      S_CLEAR: if (r_clr_idx == c_NREGS_CNT) w_next = S_ARB;
      default: w_next = S_IDLE;
    endcase
  end

  assign clear_busy = (r_state == S_CLEAR);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_last_grant <= 2'(NREQ - 1);
      r_clr_idx    <= '0;
      WE3          <= 1'b0;
      A3           <= '0;
      WD3          <= '0;
      grant_id     <= '0;
    end else begin
      r_state <= w_next;
      WE3     <= 1'b0;
      if (w_clr_go) begin
        // First clear write (address 0) is issued on entry to CLEAR.
        WE3       <= 1'b1;
        A3        <= '0;
        WD3       <= '0;
        r_clr_idx <= c_CNT_W'(1);
      end else if (w_hs) begin
        WE3          <= 1'b1;
        A3           <= w_addr;
        WD3          <= w_data;
        grant_id     <= w_gnt;
        r_last_grant <= w_gnt;
      end else if ((r_state == S_CLEAR) && (r_clr_idx != c_NREGS_CNT)) begin
        WE3       <= 1'b1;
        A3        <= r_clr_idx[ADDR_W-1:0];
        WD3       <= '0;
        r_clr_idx <= r_clr_idx + c_CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Scoreboard bench for regfile_write_arbiter (default parameters).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_arbiter;

  localparam int NREQ   = 3;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 8;

  logic                    CLK;
  logic                    RESET;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*ADDR_W-1:0]  req_addr;
  logic [NREQ*DATA_W-1:0]  req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    stall;
  logic                    clear_start;
  logic                    clear_busy;
  logic [ADDR_W-1:0]       A3;
  logic                    WE3;
  logic [DATA_W-1:0]       WD3;
  logic [1:0]              grant_id;

  regfile_write_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREGS(NREGS)
  ) u_dut (
    .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .stall(stall),
    .clear_start(clear_start), .clear_busy(clear_busy), .A3(A3), .WE3(WE3),
    .WD3(WD3), .grant_id(grant_id)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [1:0]        g;
    bit                full;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  // Reference model state: 0 idle, 1 arbitrate, 2 clearing.
  int   m_state;
  int   m_last;
  int   m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    int idx;
    for (int s = 0; s < NREQ; s++) begin
      idx = last + 1 + s;
      if (idx >= NREQ) idx = idx - NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  // Check the current cycle, then advance the model by one clock.
  task automatic cycle();
    exp_t            e;
    int              g;
    logic [NREQ-1:0] exp_rdy;
    @(negedge CLK);
    check("clear_busy", 64'(clear_busy), 64'(m_state == 2));
    g = (RESET || m_state != 1 || stall || clear_start) ? -1 : pick(req_valid, m_last);
    exp_rdy = (g < 0) ? '0 : (NREQ'(1) << g);
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("WE3", 64'(WE3), 64'(e.we));
      if (e.we || e.full) begin
        check("A3", 64'(A3), 64'(e.a));
        check("WD3", 64'(WD3), 64'(e.d));
        if (e.full || m_state != 2) check("grant_id", 64'(grant_id), 64'(e.g));
      end
    end
    e = '{we: 1'b0, a: '0, d: '0, g: '0, full: 1'b0};
    if (RESET) begin
      e.full  = 1'b1;
      m_state = 0;
      m_last  = NREQ - 1;
    end else if (m_state == 2) begin
      if (m_cnt < NREGS) begin
        e.we = 1'b1; e.a = ADDR_W'(m_cnt); m_cnt++;
      end else begin
        m_state = 1;
      end
    end else if (clear_start) begin
      e.we = 1'b1; m_state = 2; m_cnt = 1;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (g >= 0) begin
      e.we = 1'b1;
      e.a  = req_addr[g*ADDR_W +: ADDR_W];
      e.d  = req_data[g*DATA_W +: DATA_W];
      e.g  = 2'(g);
      m_last = g;
    end
    sb.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_state = 0; m_last = NREQ - 1; m_cnt = 0;
    RESET = 1'b1; stall = 1'b0; clear_start = 1'b0;
    req_valid = 3'b111; req_addr = '0; req_data = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, ADDR_W'(i + 10), 32'hA000_0000 + DATA_W'(i));
    repeat (2) cycle();

    // Reset release with all requesters valid: 0,1,2,0,...
    RESET = 1'b0;
    repeat (7) cycle();

    // Single requester 1 writing 0xDEADBEEF to register 5.
    req_valid = 3'b010;
    set_req(1, 5'd5, 32'hDEADBEEF);
    repeat (2) cycle();

    // Stall blocks grants; resume continues rotation.
    req_valid = 3'b111;
    stall = 1'b1;
    repeat (3) cycle();
    stall = 1'b0;
    repeat (3) cycle();

    // Clear sequence; stall and a second clear_start are ignored while clearing.
    req_valid = 3'b000;
    clear_start = 1'b1;
    cycle();
    clear_start = 1'b0;
    req_valid = 3'b110; stall = 1'b1;
    repeat (3) cycle();
    clear_start = 1'b1;
    cycle();
    clear_start = 1'b0;
    repeat (5) cycle();
    stall = 1'b0;
    repeat (3) cycle();

    // Clear coincident with requester 0: clear wins, requester 0 follows.
    req_valid = 3'b001;
    set_req(0, 5'd17, 32'h1234_5678);
    clear_start = 1'b1;
    cycle();
    clear_start = 1'b0;
    repeat (10) cycle();

    // Reset during the third clear write aborts the sequence.
    req_valid = 3'b000;
    clear_start = 1'b1;
    cycle();
    clear_start = 1'b0;
    repeat (2) cycle();
    RESET = 1'b1;
    cycle();
    RESET = 1'b0;
    repeat (3) cycle();

    // Reset coinciding with a would-be handshake discards it.
    req_valid = 3'b111;
    cycle();
    RESET = 1'b1;
    cycle();
    RESET = 1'b0;
    repeat (3) cycle();

    // Randomised traffic.
    for (int n = 0; n < 200; n++) begin
      req_valid   = NREQ'($urandom_range(7, 0));
      stall       = ($urandom_range(99, 0) < 20);
      clear_start = ($urandom_range(99, 0) < 4);
      RESET       = ($urandom_range(99, 0) < 2);
      for (int i = 0; i < NREQ; i++) set_req(i, ADDR_W'($urandom), DATA_W'($urandom));
      cycle();
    end
    RESET = 1'b0; clear_start = 1'b0; stall = 1'b0;
    repeat (12) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
